// File: rtl/triangle_wave_gen.sv
// triangle_wave_gen: clamped up/down ramp between live limits; MClk clock, RstN async active-high reset, En enable, UpperLimit/LowerLimit/StepSize in, TWave registered out
module triangle_wave_gen #(
  parameter int BIT_WIDTH = 16
) (
  input  logic                 MClk,
  input  logic                 RstN,
  input  logic                 En,
  input  logic [BIT_WIDTH-1:0] UpperLimit,
  input  logic [BIT_WIDTH-1:0] LowerLimit,
  input  logic [BIT_WIDTH-1:0] StepSize,
  output logic [BIT_WIDTH-1:0] TWave
);
  typedef enum logic {UP, DOWN} dir_e;
  dir_e                 dir_q, dir_d;
  logic [BIT_WIDTH-1:0] wave_q, wave_d;
  logic [BIT_WIDTH:0]   sum_up, low_step;
  always_ff @(posedge MClk or posedge RstN)
    if (RstN) begin
      wave_q <= '0;
      dir_q  <= UP;
    end else begin
      wave_q <= wave_d;
      dir_q  <= dir_d;
    end
  always_comb begin
    sum_up   = {1'b0, wave_q} + {1'b0, StepSize};
    low_step = {1'b0, LowerLimit} + {1'b0, StepSize};
    wave_d   = wave_q;
    dir_d    = dir_q;
    if (En) begin
      if (UpperLimit <= LowerLimit || wave_q < LowerLimit) begin
        wave_d = LowerLimit;
        dir_d  = UP;
      end else if (wave_q > UpperLimit) begin
        wave_d = UpperLimit;
        dir_d  = DOWN;
      end else if (dir_q == UP) begin
        wave_d = sum_up >= {1'b0, UpperLimit} ? UpperLimit : sum_up[BIT_WIDTH-1:0];
        dir_d  = sum_up >= {1'b0, UpperLimit} ? DOWN : UP;
      end else begin
        wave_d = {1'b0, wave_q} <= low_step ? LowerLimit : wave_q - StepSize;
        dir_d  = {1'b0, wave_q} <= low_step ? UP : DOWN;
      end
    end
  end
  assign TWave = wave_q;
endmodule

// File: tb/tb_triangle_wave_gen.sv
// tb_triangle_wave_gen: scoreboard bench for triangle_wave_gen with directed vectors
module tb_triangle_wave_gen;
  typedef struct {
    string       n;
    logic [15:0] v;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [15:0] up = 16'd500;
  logic [15:0] lo = 16'd250;
  logic [15:0] st = 16'd3;
  logic [15:0] tw;
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  triangle_wave_gen #(.BIT_WIDTH(16)) dut (
    .MClk(clk), .RstN(rst), .En(en), .UpperLimit(up),
    .LowerLimit(lo), .StepSize(st), .TWave(tw)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (tw !== e.v) begin
        errors++;
        $display("FAIL %s got %0d want %0d", e.n, tw, e.v);
      end
    end
  end
  task automatic cyc(input string n, input logic [15:0] v);
    exp_t e;
    e.n = n;
    e.v = v;
    sb.push_back(e);
    @(negedge clk);
  endtask
  task automatic skip(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic direct(input string n, input logic [15:0] v);
    checks++;
    if (tw !== v) begin
      errors++;
      $display("FAIL %s got %0d want %0d", n, tw, v);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end
  initial begin
    #2 rst = 1'b1;
    #1 direct("rst_async", 16'd0);
    @(negedge clk);
    cyc("rst_hold", 16'd0);
    rst = 1'b0;
    en = 1'b1;
    cyc("ramp_e1", 16'd250);
    cyc("ramp_e2", 16'd253);
    cyc("ramp_e3", 16'd256);
    cyc("ramp_e4", 16'd259);
    skip(79);
    cyc("ramp_e84", 16'd499);
    cyc("peak_e85", 16'd500);
    cyc("down_e86", 16'd497);
    skip(80);
    cyc("down_e167", 16'd254);
    cyc("down_e168", 16'd251);
    cyc("trough_e169", 16'd250);
    cyc("up_e170", 16'd253);
    skip(48);
    cyc("ramp_400", 16'd400);
    en = 1'b0;
    repeat (10) cyc("en_hold", 16'd400);
    en = 1'b1;
    cyc("en_resume", 16'd403);
    #2 rst = 1'b1;
    #1 direct("rst_mid", 16'd0);
    #1 rst = 1'b0;
    lo = 16'd0;
    st = 16'd100;
    cyc("post_rst1", 16'd100);
    cyc("post_rst2", 16'd200);
    cyc("post_rst3", 16'd300);
    up = 16'd280;
    st = 16'd3;
    cyc("upper_drop", 16'd280);
    cyc("upper_drop_dn", 16'd277);
    cyc("upper_drop_dn2", 16'd274);
    up = 16'd65535;
    st = 16'd40000;
    cyc("big_0", 16'd0);
    cyc("big_40000", 16'd40000);
    cyc("big_65535", 16'd65535);
    cyc("big_25535", 16'd25535);
    cyc("big_0b", 16'd0);
    cyc("big_40000b", 16'd40000);
    up = 16'd100;
    lo = 16'd100;
    repeat (3) cyc("eq_limits", 16'd100);
    up = 16'd200;
    st = 16'd0;
    repeat (2) cyc("step0_low", 16'd100);
    st = 16'd50;
    cyc("s50_150", 16'd150);
    cyc("s50_peak", 16'd200);
    st = 16'd0;
    repeat (2) cyc("step0_high", 16'd200);
    st = 16'd50;
    cyc("s50_dn150", 16'd150);
    cyc("s50_trough", 16'd100);
    cyc("s50_up150", 16'd150);
    up = 16'd200;
    lo = 16'd300;
    repeat (2) cyc("inverted", 16'd300);
    skip(2);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
